// File: rtl/axi_enhanced_rx_np_sched_if.sv
// NP scheduler bus: link state, request pulses and demux pop strobe in;
// the paced PCIe NP request, FIFO head owner, occupancy and sticky flags out.
interface axi_enhanced_rx_np_sched_if #(
  parameter int unsigned C_MAX_CREDITS = 8,
  parameter int unsigned CNT_WIDTH     = $clog2(C_MAX_CREDITS + 1)
);
  logic                 trn_lnk_up;
  logic                 rx_np_req;
  logic                 cfg_req;
  logic                 np_tlp_sof;
  logic                 rnp_req;
  logic                 np_owner;
  logic                 np_owner_vld;
  logic [CNT_WIDTH-1:0] np_outstanding;
  logic                 req_ovf;
  logic                 np_err;

  modport master (
    output trn_lnk_up, rx_np_req, cfg_req, np_tlp_sof,
    input  rnp_req, np_owner, np_owner_vld, np_outstanding, req_ovf, np_err
  );

  modport slave (
    input  trn_lnk_up, rx_np_req, cfg_req, np_tlp_sof,
    output rnp_req, np_owner, np_owner_vld, np_outstanding, req_ovf, np_err
  );
endinterface

// File: rtl/axi_enhanced_rx_np_sched.sv
// Round-robin NP credit scheduler between user and config requesters, with a
// paced rnp_req pulse and an in-order owner FIFO used to steer returning NP TLPs.
module axi_enhanced_rx_np_sched #(
  parameter int unsigned C_MAX_CREDITS = 8,
  parameter int unsigned C_PEND_MAX    = 15,
  parameter int unsigned C_REQ_GAP     = 2,
  parameter int          TCQ           = 1,
  parameter int unsigned CNT_WIDTH     = $clog2(C_MAX_CREDITS + 1)
) (
  input  logic                         com_iclk,
  input  logic                         com_sysrst_n,
  axi_enhanced_rx_np_sched_if.slave    np_if
);

  localparam int unsigned IDX_W = $clog2(C_MAX_CREDITS);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [3:0]  PEND_MAX = 4'(C_PEND_MAX);
  localparam logic [3:0]  GAP_LOAD = 4'(C_REQ_GAP);

  if (C_MAX_CREDITS < 2 || C_MAX_CREDITS > 32 || (C_MAX_CREDITS & (C_MAX_CREDITS - 1)) != 0 ||
      C_PEND_MAX > 15 || C_REQ_GAP > 15 || TCQ < 0 || CNT_WIDTH != PTR_W) begin : g_param_err
    $error("axi_enhanced_rx_np_sched: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FLUSH} state_t;

  state_t                   state;
  logic [3:0]               usr_pend;
  logic [3:0]               cfg_pend;
  logic [3:0]               gap_cnt;
  logic                     last_grant;
  logic [C_MAX_CREDITS-1:0] own_mem;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     rnp_req_q;
  logic                     req_ovf_q;
  logic                     np_err_q;

  logic             flush;
  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] occ_eff;
  logic             fifo_empty;
  logic             pop;
  logic             empty_pop;
  logic             usr_p;
  logic             cfg_p;
  logic             grant;
  logic             gnt_cfg;
  logic             usr_inc;
  logic             cfg_inc;
  logic             usr_dec;
  logic             cfg_dec;
  logic [3:0]       usr_pend_nxt;
  logic [3:0]       cfg_pend_nxt;
  logic             usr_ovf;
  logic             cfg_ovf;

  always_comb begin
    flush      = !np_if.trn_lnk_up || (state == FLUSH);
    occ        = wr_ptr - rd_ptr;
    fifo_empty = (occ == '0);
    pop        = np_if.np_tlp_sof && !fifo_empty && !flush;
    empty_pop  = np_if.np_tlp_sof && fifo_empty && !flush;
    // A same-cycle pop frees a slot for this cycle's grant
    occ_eff    = occ - PTR_W'(pop);
    usr_p      = (usr_pend != '0);
    cfg_p      = (cfg_pend != '0);
    gnt_cfg    = (usr_p && cfg_p) ? ~last_grant : cfg_p;
    grant      = (state == IDLE) && !flush && (usr_p || cfg_p) &&
                 (occ_eff < PTR_W'(C_MAX_CREDITS));
    usr_inc    = np_if.rx_np_req && !flush;
    cfg_inc    = np_if.cfg_req && !flush;
    usr_dec    = grant && !gnt_cfg;
    cfg_dec    = grant && gnt_cfg;

    usr_pend_nxt = usr_pend;
    usr_ovf      = 1'b0;
    if (usr_inc && !usr_dec) begin
      if (usr_pend == PEND_MAX) usr_ovf = 1'b1;
      else                      usr_pend_nxt = usr_pend + 4'd1;
    end else if (!usr_inc && usr_dec) begin
      usr_pend_nxt = usr_pend - 4'd1;
    end

    cfg_pend_nxt = cfg_pend;
    cfg_ovf      = 1'b0;
    if (cfg_inc && !cfg_dec) begin
      if (cfg_pend == PEND_MAX) cfg_ovf = 1'b1;
      else                      cfg_pend_nxt = cfg_pend + 4'd1;
    end else if (!cfg_inc && cfg_dec) begin
      cfg_pend_nxt = cfg_pend - 4'd1;
    end
  end

  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      state      <= IDLE;
      usr_pend   <= '0;
      cfg_pend   <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      own_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rnp_req_q  <= 1'b0;
      req_ovf_q  <= 1'b0;
      np_err_q   <= 1'b0;
    end else begin
      if (empty_pop)          np_err_q  <= 1'b1;
      if (usr_ovf || cfg_ovf) req_ovf_q <= 1'b1;

      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        usr_pend  <= '0;
        cfg_pend  <= '0;
        gap_cnt   <= '0;
        rnp_req_q <= 1'b0;
        state     <= np_if.trn_lnk_up ? IDLE : FLUSH;
      end else begin
        usr_pend <= usr_pend_nxt;
        cfg_pend <= cfg_pend_nxt;
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (grant) begin
          own_mem[wr_ptr[IDX_W-1:0]] <= gnt_cfg;
          wr_ptr     <= wr_ptr + PTR_W'(1);
          last_grant <= gnt_cfg;
        end

        unique case (state)
          IDLE: begin
            if (grant) begin
              state     <= ISSUE;
              rnp_req_q <= 1'b1;
            end
          end
          ISSUE: begin
            rnp_req_q <= 1'b0;
            if (C_REQ_GAP == 0) begin
              state <= IDLE;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
          GAP: begin
            if (gap_cnt <= 4'd1) begin
              state   <= IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign np_if.rnp_req        = rnp_req_q;
  assign np_if.np_owner_vld   = !fifo_empty && (state != FLUSH);
  assign np_if.np_owner       = np_if.np_owner_vld ? own_mem[rd_ptr[IDX_W-1:0]] : 1'b0;
  assign np_if.np_outstanding = CNT_WIDTH'(occ);
  assign np_if.req_ovf        = req_ovf_q;
  assign np_if.np_err         = np_err_q;

endmodule

// File: tb/tb_axi_enhanced_rx_np_sched.sv
// Directed bench for the NP scheduler: reset, single request, round robin,
// FIFO full / pending saturation, empty pop, async reset and link drop.
module tb_axi_enhanced_rx_np_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  axi_enhanced_rx_np_sched_if #(.C_MAX_CREDITS(8)) np_if ();

  axi_enhanced_rx_np_sched #(
    .C_MAX_CREDITS (8),
    .C_PEND_MAX    (15),
    .C_REQ_GAP     (2),
    .TCQ           (1)
  ) dut (
    .com_iclk     (clk),
    .com_sysrst_n (rst_n),
    .np_if        (np_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    np_if.trn_lnk_up = 1'b1;
    np_if.rx_np_req  = 1'b0;
    np_if.cfg_req    = 1'b0;
    np_if.np_tlp_sof = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pt[8];

    // Reset state with link up
    np_if.trn_lnk_up = 1'b1;
    np_if.rx_np_req  = 1'b0;
    np_if.cfg_req    = 1'b0;
    np_if.np_tlp_sof = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_rnp_req", np_if.rnp_req, 0);
    check("rst_owner", np_if.np_owner, 0);
    check("rst_owner_vld", np_if.np_owner_vld, 0);
    check("rst_outstanding", np_if.np_outstanding, 0);
    check("rst_req_ovf", np_if.req_ovf, 0);
    check("rst_np_err", np_if.np_err, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (np_if.rnp_req) n++;
    end
    check("idle_pulses", n, 0);

    // Single user request: pulse two edges after the request
    np_if.rx_np_req = 1'b1;
    tick();
    np_if.rx_np_req = 1'b0;
    check("single_early", np_if.rnp_req, 0);
    tick();
    check("single_pulse", np_if.rnp_req, 1);
    check("single_vld", np_if.np_owner_vld, 1);
    check("single_owner", np_if.np_owner, 0);
    check("single_outst", np_if.np_outstanding, 1);
    tick();
    check("single_width", np_if.rnp_req, 0);
    tick();
    np_if.np_tlp_sof = 1'b1;
    tick();
    np_if.np_tlp_sof = 1'b0;
    check("single_pop_outst", np_if.np_outstanding, 0);
    check("single_pop_vld", np_if.np_owner_vld, 0);
    check("single_no_err", np_if.np_err, 0);

    // Round robin: 3 pulses on each requester
    do_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      np_if.rx_np_req = (i < 3);
      np_if.cfg_req   = (i < 3);
      tick();
      if (np_if.rnp_req) begin
        if (n < 8) pt[n] = i;
        n++;
      end
    end
    check("rr_pulses", n, 6);
    check("rr_latency", pt[0], 1);
    for (int k = 1; k < 6 && k < n; k++) check("rr_spacing", pt[k] - pt[k-1], 4);
    check("rr_outst", np_if.np_outstanding, 6);
    np_if.np_tlp_sof = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("rr_vld", np_if.np_owner_vld, 1);
      check("rr_owner", np_if.np_owner, k % 2);
      tick();
    end
    np_if.np_tlp_sof = 1'b0;
    check("rr_drained", np_if.np_owner_vld, 0);

    // Empty pop, FIFO full, pending saturation, pop frees one grant
    do_reset();
    np_if.np_tlp_sof = 1'b1;
    tick();
    np_if.np_tlp_sof = 1'b0;
    check("empty_pop_err", np_if.np_err, 1);
    check("empty_pop_outst", np_if.np_outstanding, 0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      np_if.rx_np_req = (i < 20);
      tick();
      if (np_if.rnp_req) n++;
    end
    check("full_pulses", n, 8);
    check("full_outst", np_if.np_outstanding, 8);
    check("full_no_ovf", np_if.req_ovf, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      np_if.rx_np_req = (i < 8);
      tick();
      if (np_if.rnp_req) n++;
    end
    check("sat_pulses", n, 0);
    check("sat_ovf", np_if.req_ovf, 1);
    np_if.np_tlp_sof = 1'b1;
    tick();
    np_if.np_tlp_sof = 1'b0;
    check("pop_grant_pulse", np_if.rnp_req, 1);
    check("pop_grant_outst", np_if.np_outstanding, 8);

    // Asynchronous reset in the middle of ISSUE
    rst_n = 1'b0;
    #1;
    check("async_rnp_req", np_if.rnp_req, 0);
    check("async_outst", np_if.np_outstanding, 0);
    check("async_ovf", np_if.req_ovf, 0);
    check("async_err", np_if.np_err, 0);
    tick();
    rst_n = 1'b1;

    // Link drop during ISSUE with 3 outstanding and 2 pending
    do_reset();
    np_if.np_tlp_sof = 1'b1;
    tick();
    np_if.np_tlp_sof = 1'b0;
    check("ld_err_set", np_if.np_err, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      np_if.rx_np_req = (i < 5);
      tick();
      if (np_if.rnp_req) n++;
      if (n == 3) break;
    end
    np_if.rx_np_req = 1'b0;
    check("ld_pulses", n, 3);
    check("ld_issue", np_if.rnp_req, 1);
    check("ld_outst_before", np_if.np_outstanding, 3);
    np_if.trn_lnk_up = 1'b0;
    tick();
    check("ld_rnp_drop", np_if.rnp_req, 0);
    check("ld_outst_flush", np_if.np_outstanding, 0);
    check("ld_vld_flush", np_if.np_owner_vld, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (np_if.rnp_req) n++;
    end
    check("ld_low_pulses", n, 0);
    np_if.trn_lnk_up = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (np_if.rnp_req) n++;
    end
    check("ld_up_pulses", n, 0);
    check("ld_err_kept", np_if.np_err, 1);
    check("ld_ovf_kept", np_if.req_ovf, 0);
    check("ld_outst_after", np_if.np_outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
